// File: rtl/mul_top.sv
// mul_top: iterative RV32M multiplier (MUL, MULH, MULHSU, MULHU).
// Operands are latched as magnitudes on start. A radix-2 shift-add loop then
// builds the 2*XLEN-bit product, which is sign-corrected on the final edge.
// The upper or lower half is returned with a one-cycle done pulse.
// Optional feature macro: MUL_EARLY_OUT_EN. When defined, the loop finishes
// as soon as the remaining multiplier bits are all zero. Results are the same.
module mul_top #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic [2:0]      i_f3,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    output logic [XLEN-1:0] o_res,
    output logic            o_done,
    output logic            o_busy
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nx_s;
    logic [1:0]          op_r;
    logic                neg_r;
    logic [2*XLEN-1:0]   a_r;
    logic [XLEN-1:0]     b_r;
    logic [2*XLEN-1:0]   p_r;
    logic [CW-1:0]       cnt_r;
    logic [XLEN-1:0]     res_r;
    logic                done_r;
    logic                busy_r;

    logic                rs1_neg_s;
    logic                rs2_neg_s;
    logic [XLEN-1:0]     a_mag_s;
    logic [XLEN-1:0]     b_mag_s;
    logic [2*XLEN-1:0]   p_next_s;
    logic [2*XLEN-1:0]   q_s;
    logic [XLEN-1:0]     b_shift_s;
    logic [XLEN-1:0]     res_sel_s;
    logic                last_s;
    logic                load_s;
    logic                step_s;
    logic                finish_s;
    logic                zero_s;

    // Operand decode: signedness per opcode, then magnitudes and product sign.
    // MUL/MULH treat both operands as signed, MULHSU only rs1, MULHU neither.
    // Negating 0x80000000 yields 0x80000000, which is the correct unsigned magnitude.
    always_comb begin
        rs1_neg_s = (i_f3[1:0] != 2'b11) && i_rs1[XLEN-1];
        rs2_neg_s = (i_f3[1] == 1'b0) && i_rs2[XLEN-1];
        if (rs1_neg_s) begin
            a_mag_s = -i_rs1;
        end else begin
            a_mag_s = i_rs1;
        end
        if (rs2_neg_s) begin
            b_mag_s = -i_rs2;
        end else begin
            b_mag_s = i_rs2;
        end
    end

    // One shift-add step. The sign correction and half selection are applied
    // to the post-step product, so the last CALC edge can register the result.
    always_comb begin
        if (b_r[0]) begin
            p_next_s = p_r + a_r;
        end else begin
            p_next_s = p_r;
        end
        if (neg_r) begin
            q_s = -p_next_s;
        end else begin
            q_s = p_next_s;
        end
        if (op_r == 2'b00) begin
            res_sel_s = q_s[XLEN-1:0];
        end else begin
            res_sel_s = q_s[2*XLEN-1:XLEN];
        end
        b_shift_s = b_r >> 1'b1;
`ifdef MUL_EARLY_OUT_EN
        last_s = (b_shift_s == {XLEN{1'b0}}) || (cnt_r == CNT_LAST);
`else
        last_s = (cnt_r == CNT_LAST);
`endif
    end

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state and datapath control strobes.
    always_comb begin
        state_nx_s = state_r;
        load_s     = 1'b0;
        step_s     = 1'b0;
        finish_s   = 1'b0;
        zero_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (i_start) begin
                    load_s = 1'b1;
`ifdef MUL_EARLY_OUT_EN
                    if (b_mag_s == {XLEN{1'b0}}) begin
                        state_nx_s = ST_DONE;
                        zero_s     = 1'b1;
                    end else begin
                        state_nx_s = ST_CALC;
                    end
`else
                    state_nx_s = ST_CALC;
`endif
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                step_s = 1'b1;
                if (last_s) begin
                    state_nx_s = ST_DONE;
                    finish_s   = 1'b1;
                end else begin
                    state_nx_s = ST_CALC;
                end
            end
            ST_DONE: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Datapath registers, the held result and the registered status outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            op_r   <= 2'b00;
            neg_r  <= 1'b0;
            a_r    <= {(2*XLEN){1'b0}};
            b_r    <= {XLEN{1'b0}};
            p_r    <= {(2*XLEN){1'b0}};
            cnt_r  <= {CW{1'b0}};
            res_r  <= {XLEN{1'b0}};
            done_r <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            if (load_s) begin
                op_r  <= i_f3[1:0];
                neg_r <= rs1_neg_s ^ rs2_neg_s;
                a_r   <= {{XLEN{1'b0}}, a_mag_s};
                b_r   <= b_mag_s;
                p_r   <= {(2*XLEN){1'b0}};
                cnt_r <= {CW{1'b0}};
            end else if (step_s) begin
                p_r   <= p_next_s;
                a_r   <= a_r << 1'b1;
                b_r   <= b_shift_s;
                cnt_r <= cnt_r + CNT_ONE;
            end
            if (finish_s) begin
                res_r <= res_sel_s;
            end else if (zero_s) begin
                res_r <= {XLEN{1'b0}};
            end
            done_r <= (state_nx_s == ST_DONE);
            busy_r <= (state_nx_s != ST_IDLE);
        end
    end

    assign o_res  = res_r;
    assign o_done = done_r;
    assign o_busy = busy_r;

endmodule
